// File: rtl/qarma128_tweak_scheduler.sv
// QARMA-128 tweak scheduler: streams the forward, reflector and backward round tweaks
// over a valid/ready port, recomputing each tweak in place from a single register.
module qarma128_tweak_scheduler #(
  parameter int unsigned ROUNDS = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] tweak_in,
  output logic         busy,
  output logic         tk_valid,
  input  logic         tk_ready,
  output logic [127:0] tk_data,
  output logic [3:0]   tk_round,
  output logic [1:0]   tk_phase,
  output logic         tk_last,
  output logic         done
);

  typedef enum logic [2:0] {
    StIdle,
    StFwd,
    StRefl,
    StBwd,
    StDone
  } state_e;

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  localparam logic [3:0] HPerm    [16] = '{4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
                                           4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
  localparam logic [3:0] HInvPerm [16] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
                                           4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3};
  // Bit k set means cell k goes through the LFSR step (cells 0,1,3,4,8,11,13).
  localparam logic [15:0] WCells = 16'h291B;

  function automatic logic [7:0] w_cell(input logic [7:0] c);
    return {c[0] ^ c[2], c[7:1]};
  endfunction

  function automatic logic [7:0] w_inv_cell(input logic [7:0] n);
    return {n[6:0], n[7] ^ n[1]};
  endfunction

  function automatic logic [127:0] tweak_h(input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = t[127-8*int'(HPerm[i]) -: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] tweak_h_inv(input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = t[127-8*int'(HInvPerm[i]) -: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] tweak_w(input logic [127:0] t);
    logic [127:0] r;
    r = t;
    for (int i = 0; i < 16; i++) begin
      if (WCells[i]) r[127-8*i -: 8] = w_cell(t[127-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] tweak_w_inv(input logic [127:0] t);
    logic [127:0] r;
    r = t;
    for (int i = 0; i < 16; i++) begin
      if (WCells[i]) r[127-8*i -: 8] = w_inv_cell(t[127-8*i -: 8]);
    end
    return r;
  endfunction

  state_e       state_q;
  logic [127:0] tr_q;
  logic [3:0]   cnt_q;

  // The backward pass regenerates T_j by inverting the forward step, so only one
  // tweak register is ever needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFwd;
            tr_q    <= tweak_in;
            cnt_q   <= '0;
          end
        end
        StFwd: begin
          if (tk_ready) begin
            if (cnt_q == LastRound) begin
              state_q <= StRefl;
            end else begin
              tr_q  <= tweak_w(tweak_h(tr_q));
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StRefl: begin
          if (tk_ready) state_q <= StBwd;
        end
        StBwd: begin
          if (tk_ready) begin
            if (cnt_q == 4'd0) begin
              state_q <= StDone;
            end else begin
              tr_q  <= tweak_h_inv(tweak_w_inv(tr_q));
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; data fields read zero outside a beat.
  always_comb begin
    busy     = 1'b0;
    tk_valid = 1'b0;
    tk_data  = '0;
    tk_round = '0;
    tk_phase = 2'd0;
    tk_last  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StFwd: begin
        busy     = 1'b1;
        tk_valid = 1'b1;
        tk_data  = tr_q;
        tk_round = cnt_q;
        tk_phase = 2'd0;
      end
      StRefl: begin
        busy     = 1'b1;
        tk_valid = 1'b1;
        tk_data  = tr_q;
        tk_round = cnt_q;
        tk_phase = 2'd1;
      end
      StBwd: begin
        busy     = 1'b1;
        tk_valid = 1'b1;
        tk_data  = tr_q;
        tk_round = cnt_q;
        tk_phase = 2'd2;
        tk_last  = (cnt_q == 4'd0);
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/qarma128_tweak_scheduler.md
QARMA128_TWEAK_SCHEDULER -- requirements
Module: qarma128_tweak_scheduler

Interface
REQ-001 Parameter ROUNDS, default 11, is the number of forward rounds; legal range 2..15.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  is the synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  is a one-cycle request to begin a schedule; it is honoured only in IDLE.
REQ-005 tweak_in  input  128  is the initial tweak T_0, captured on the cycle start is accepted.
REQ-006 busy  output  1  is high from the cycle after start is accepted until the cycle after the last beat handshakes.
REQ-007 tk_valid  output  1  is high while tk_data holds a valid round tweak.
REQ-008 tk_ready  input  1  is the consumer acceptance; a beat transfers on tk_valid & tk_ready.
REQ-009 tk_data  output  128  is the round tweak.
REQ-010 tk_round  output  4  is the round index of the current beat.
REQ-011 tk_phase  output  2  is the beat phase: 0 = FWD, 1 = REFL, 2 = BWD.
REQ-012 tk_last  output  1  is high on the final beat only.
REQ-013 done  output  1  is a one-cycle pulse in the cycle after the final beat transfers.

Function
REQ-014 Cell k (k = 0..15) of a 128-bit word SHALL be bits [127-8k : 120-8k], so cell 0 is the MSB byte.
REQ-015 h(T): output cell i = input cell P[i], with P = 6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11.
REQ-016 h_inv(T): output cell i = input cell Q[i], with Q = 4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3.
REQ-017 w(T): cells 0,1,3,4,8,11,13 map c -> {c[0]^c[2], c[7:1]}; all other cells pass unchanged.
REQ-018 w_inv(T): the same cells map n -> {n[6:0], n[7]^n[1]}; all other cells pass unchanged.
REQ-019 FSM states SHALL be IDLE, FWD, REFL, BWD and DONE.
REQ-020 IDLE + start -> FWD; the register TR loads tweak_in and the round counter loads 0.
REQ-021 In FWD, beat j (j = 0..ROUNDS-1) SHALL present T_j with tk_round = j, where T_j = w(h(T_{j-1})).
REQ-022 TR SHALL be updated only on a FWD handshake with j < ROUNDS-1.
REQ-023 A handshake on FWD beat ROUNDS-1 -> REFL.
REQ-024 REFL presents one beat: T_{ROUNDS-1}, tk_round = ROUNDS-1, tk_phase = 1; TR is unchanged.
REQ-025 A REFL handshake -> BWD with the counter at ROUNDS-1.
REQ-026 BWD beat j (descending from ROUNDS-1 to 0) presents T_j.
REQ-027 On a BWD handshake with j > 0, TR <= h_inv(w_inv(TR)) and the counter decrements.
REQ-028 A handshake on BWD beat 0 (tk_last = 1) -> DONE.
REQ-029 DONE lasts one cycle, asserts done, then -> IDLE.
REQ-030 A schedule is exactly 2*ROUNDS+1 beats.
REQ-031 Latency: start accepted at cycle N -> tk_valid = 1 with T_0 at cycle N+1.
REQ-032 Consecutive beats SHALL issue back-to-back when tk_ready is held high.
REQ-033 While tk_valid & !tk_ready, tk_data, tk_round, tk_phase and tk_last SHALL hold stable.
REQ-034 tk_valid SHALL never deassert without a handshake.
REQ-035 start while not in IDLE (including DONE) SHALL be ignored with no effect.
REQ-036 start in the same cycle as done SHALL be ignored.
REQ-037 tk_ready while tk_valid = 0 SHALL have no effect.
REQ-038 Each tweak update SHALL be a single-cycle combinational step between registers, with no extra pipeline latency.

Reset
REQ-039 rst = 1 SHALL force IDLE, TR = 0 and counter = 0.
REQ-040 Under rst, busy, tk_valid, tk_last and done = 0; tk_data = 0, tk_round = 0, tk_phase = 0.
REQ-041 rst overrides start and any in-flight schedule; the schedule is abandoned with no done pulse.

Verification
REQ-042 tweak_in = 0, tk_ready = 1 -> 23 consecutive beats, all tk_data = 0; tk_last on beat 23; done the next cycle.
REQ-043 tweak_in = 128'h01000000_00000000_00000000_00000000 -> beat 0 = tweak_in; beat 1 = 128'h00000000_80000000_00000000_00000000 (round 1, FWD).
REQ-044 Random tweak_in, random tk_ready -> BWD round-0 beat equals tweak_in; FWD beat j equals BWD beat j for all j.
REQ-045 tk_ready low for 5 cycles at FWD beat 3 -> all beat outputs stable; beat 4 follows one cycle after tk_ready rises.
REQ-046 start pulsed during FWD beat 2 with a different tweak_in -> ignored; the sequence is unchanged.
REQ-047 rst asserted during BWD -> all outputs per REQ-040 next cycle, no done; a new start then yields T_0 one cycle later.
